// File: rtl/axil4_slave.sv
// AXI4-Lite slave exposing a bank of NUM_REGS read/write registers.
// The write and read channels each have their own small FSM and run
// concurrently. Every output comes straight from a flop.
module axil4_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ADDR_WIDTH-1:0]     ARADDR,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wrState_t;
  typedef enum logic {RD_IDLE, RD_DATA} rdState_t;

  // Register bank
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  // Write channel state and registered outputs
  wrState_t              r_wrState;
  logic                  r_awDone;
  logic                  r_wDone;
  logic [ADDR_WIDTH-1:0] r_awAddr;
  logic [DATA_WIDTH-1:0] r_wData;
  logic [STRB_W-1:0]     r_wStrb;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;

  // Write channel next-state values
  wrState_t              w_wrStateNext;
  logic                  w_awDoneNext;
  logic                  w_wDoneNext;
  logic                  w_awreadyNext;
  logic                  w_wreadyNext;
  logic                  w_bvalidNext;
  logic [1:0]            w_brespNext;

  // Write channel helpers
  logic                  w_awHs;
  logic                  w_wHs;
  logic                  w_awHave;
  logic                  w_wHave;
  logic [ADDR_WIDTH-1:0] w_wrAddr;
  logic [DATA_WIDTH-1:0] w_wrData;
  logic [STRB_W-1:0]     w_wrStrb;
  logic                  w_wrInRange;
  logic [IDX_W-1:0]      w_wrIdx;
  logic                  w_wrCommit;

  // Read channel state and registered outputs
  rdState_t              r_rdState;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  // Read channel next-state values and helpers
  rdState_t              w_rdStateNext;
  logic                  w_arreadyNext;
  logic                  w_rvalidNext;
  logic [DATA_WIDTH-1:0] w_rdataNext;
  logic [1:0]            w_rrespNext;
  logic                  w_arHs;
  logic                  w_rdInRange;
  logic [IDX_W-1:0]      w_rdIdx;

  assign AWREADY = r_awready;
  assign WREADY  = r_wready;
  assign BVALID  = r_bvalid;
  assign BRESP   = r_bresp;
  assign ARREADY = r_arready;
  assign RVALID  = r_rvalid;
  assign RDATA   = r_rdata;
  assign RRESP   = r_rresp;

  // A beat counts only while our READY is high. The commit uses either the
  // captured AW/W or the one arriving this very edge, so the second of the
  // two handshakes completes the write with no extra cycle.
  assign w_awHs      = AWVALID && r_awready;
  assign w_wHs       = WVALID && r_wready;
  assign w_awHave    = r_awDone || w_awHs;
  assign w_wHave     = r_wDone || w_wHs;
  assign w_wrAddr    = r_awDone ? r_awAddr : AWADDR;
  assign w_wrData    = r_wDone ? r_wData : WDATA;
  assign w_wrStrb    = r_wDone ? r_wStrb : WSTRB;
  assign w_wrInRange = (w_wrAddr < ADDR_LIMIT);
  assign w_wrIdx     = w_wrAddr[IDX_W+1:2];
  assign w_wrCommit  = (r_wrState == WR_IDLE) && w_awHave && w_wHave;

  assign w_arHs      = ARVALID && r_arready;
  assign w_rdInRange = (ARADDR < ADDR_LIMIT);
  assign w_rdIdx     = ARADDR[IDX_W+1:2];

  // Write FSM next-state and next-output logic
  always_comb begin
    w_wrStateNext = r_wrState;
    w_awDoneNext  = r_awDone;
    w_wDoneNext   = r_wDone;
    w_awreadyNext = r_awready;
    w_wreadyNext  = r_wready;
    w_bvalidNext  = r_bvalid;
    w_brespNext   = r_bresp;
    case (r_wrState)
      WR_IDLE: begin
        if (w_wrCommit) begin
          w_wrStateNext = WR_RESP;
          w_awDoneNext  = 1'b0;
          w_wDoneNext   = 1'b0;
          w_awreadyNext = 1'b0;
          w_wreadyNext  = 1'b0;
          w_bvalidNext  = 1'b1;
          w_brespNext   = w_wrInRange ? RESP_OKAY : RESP_SLVERR;
        end else begin
          w_awDoneNext  = w_awHave;
          w_wDoneNext   = w_wHave;
          w_awreadyNext = !w_awHave;
          w_wreadyNext  = !w_wHave;
        end
      end
      WR_RESP: begin
        if (r_bvalid && BREADY) begin
          w_wrStateNext = WR_IDLE;
          w_bvalidNext  = 1'b0;
          w_awreadyNext = 1'b1;
          w_wreadyNext  = 1'b1;
        end
      end
      default: w_wrStateNext = WR_IDLE;
    endcase
  end

  // Write FSM state, handshake flags and write-channel outputs
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wrState <= WR_IDLE;
      r_awDone  <= 1'b0;
      r_wDone   <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wrState <= w_wrStateNext;
      r_awDone  <= w_awDoneNext;
      r_wDone   <= w_wDoneNext;
      r_awready <= w_awreadyNext;
      r_wready  <= w_wreadyNext;
      r_bvalid  <= w_bvalidNext;
      r_bresp   <= w_brespNext;
    end
  end

  // Hold the first-arriving AW or W beat until its partner shows up
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awAddr <= '0;
      r_wData  <= '0;
      r_wStrb  <= '0;
    end else begin
      if (w_awHs) begin
        r_awAddr <= AWADDR;
      end
      if (w_wHs) begin
        r_wData <= WDATA;
        r_wStrb <= WSTRB;
      end
    end
  end

  // Register bank: byte-masked update on an in-range write commit
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wrCommit && w_wrInRange) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_wrStrb[b]) begin
          r_regs[w_wrIdx][8*b +: 8] <= w_wrData[8*b +: 8];
        end
      end
    end
  end

  // Read FSM next-state and next-output logic; RDATA samples the bank
  // before any same-edge write lands, so a colliding read sees old data
  always_comb begin
    w_rdStateNext = r_rdState;
    w_arreadyNext = r_arready;
    w_rvalidNext  = r_rvalid;
    w_rdataNext   = r_rdata;
    w_rrespNext   = r_rresp;
    case (r_rdState)
      RD_IDLE: begin
        if (w_arHs) begin
          w_rdStateNext = RD_DATA;
          w_arreadyNext = 1'b0;
          w_rvalidNext  = 1'b1;
          w_rdataNext   = w_rdInRange ? r_regs[w_rdIdx] : '0;
          w_rrespNext   = w_rdInRange ? RESP_OKAY : RESP_SLVERR;
        end else begin
          w_arreadyNext = 1'b1;
        end
      end
      RD_DATA: begin
        if (r_rvalid && RREADY) begin
          w_rdStateNext = RD_IDLE;
          w_rvalidNext  = 1'b0;
          w_arreadyNext = 1'b1;
        end
      end
      default: w_rdStateNext = RD_IDLE;
    endcase
  end

  // Read FSM state and read-channel outputs
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rdState <= RD_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_rdState <= w_rdStateNext;
      r_arready <= w_arreadyNext;
      r_rvalid  <= w_rvalidNext;
      r_rdata   <= w_rdataNext;
      r_rresp   <= w_rrespNext;
    end
  end

endmodule

// File: tb/tb_axil4_slave.sv
// Self-checking bench for axil4_slave: a byte-accurate register model
// feeds expected B and R responses into queues as transactions are
// driven; negedge monitors pop and compare them as the DUT responds.
module tb_axil4_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic [AW-1:0] AWADDR = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b1;
  logic [AW-1:0] ARADDR = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY = 1'b1;

  int totalChecks = 0;
  int badChecks = 0;

  logic [DW-1:0]   model [NR];
  logic [1:0]      expB [$];
  logic [DW+1:0]   expR [$];

  axil4_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  // 100 MHz clock
  always #5 ACLK = ~ACLK;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit inRange(input logic [AW-1:0] addr);
    return addr < AW'(NR * 4);
  endfunction

  // Reference register model update with byte strobes
  function automatic void modelWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                     input logic [3:0] strb);
    if (inRange(addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model[addr[5:2]][8*b +: 8] = data[8*b +: 8];
      end
    end
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endfunction

  // Write-response monitor: the handshake completes on the next rising edge
  always @(negedge ACLK) begin
    if (!ARESET && BVALID && BREADY) begin
      checkOutput("b_expected", 64'(expB.size() > 0), 64'd1);
      if (expB.size() > 0) checkOutput("bresp", 64'(BRESP), 64'(expB.pop_front()));
    end
  end

  // Read-data monitor
  always @(negedge ACLK) begin
    if (!ARESET && RVALID && RREADY) begin
      checkOutput("r_expected", 64'(expR.size() > 0), 64'd1);
      if (expR.size() > 0) checkOutput("rresp_rdata", 64'({RRESP, RDATA}), 64'(expR.pop_front()));
    end
  end

  // Drives AW and W with independent start delays; returns #1 after the commit edge
  task automatic applyWriteStimulus(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                    input logic [3:0] strb, input int awDelay, input int wDelay);
    bit awDone = 1'b0;
    bit wDone = 1'b0;
    bit hsAw;
    bit hsW;
    int cyc = 0;
    expB.push_back(inRange(addr) ? 2'b00 : 2'b10);
    AWADDR = addr;
    WDATA = data;
    WSTRB = strb;
    while (!(awDone && wDone) && cyc < 50) begin
      AWVALID = !awDone && (cyc >= awDelay);
      WVALID = !wDone && (cyc >= wDelay);
      @(negedge ACLK);
      hsAw = AWVALID && AWREADY;
      hsW = WVALID && WREADY;
      @(posedge ACLK);
      #1;
      if (hsAw) begin awDone = 1'b1; AWVALID = 1'b0; end
      if (hsW) begin wDone = 1'b1; WVALID = 1'b0; end
      if (hsW && !awDone) checkOutput("wready_low_after_w", 64'(WREADY), 64'd0);
      if (hsAw && !wDone) checkOutput("awready_low_after_aw", 64'(AWREADY), 64'd0);
      cyc++;
    end
    AWVALID = 1'b0;
    WVALID = 1'b0;
    checkOutput("write_handshakes", 64'({awDone, wDone}), 64'd3);
    if (awDone && wDone) begin
      modelWrite(addr, data, strb);
      checkOutput("bvalid_latency", 64'(BVALID), 64'd1);
    end
  endtask

  // Drives one AR beat; returns #1 after the handshake edge
  task automatic applyReadStimulus(input logic [AW-1:0] addr);
    bit hs = 1'b0;
    int cyc = 0;
    expR.push_back(inRange(addr) ? {2'b00, model[addr[5:2]]} : {2'b10, 32'h0});
    ARADDR = addr;
    ARVALID = 1'b1;
    while (!hs && cyc < 50) begin
      @(negedge ACLK);
      hs = ARVALID && ARREADY;
      @(posedge ACLK);
      #1;
      cyc++;
    end
    ARVALID = 1'b0;
    checkOutput("read_handshake", 64'(hs), 64'd1);
    if (hs) checkOutput("rvalid_latency", 64'(RVALID), 64'd1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence
  initial begin
    modelReset();
    idleCycles(3);
    checkOutput("rst_readies", 64'({AWREADY, WREADY, ARREADY}), 64'd0);
    checkOutput("rst_valids", 64'({BVALID, RVALID}), 64'd0);
    checkOutput("rst_resps", 64'({BRESP, RRESP}), 64'd0);
    checkOutput("rst_rdata", 64'(RDATA), 64'd0);
    ARESET = 1'b0;
    idleCycles(1);
    checkOutput("post_rst_readies", 64'({AWREADY, WREADY, ARREADY}), 64'd7);

    // Same-cycle AW and W, then read back
    applyWriteStimulus(32'h08, 32'hDEADBEEF, 4'hF, 0, 0);
    applyReadStimulus(32'h08);
    idleCycles(2);

    // W three cycles ahead of AW
    applyWriteStimulus(32'h0C, 32'h11223344, 4'hF, 3, 0);
    applyReadStimulus(32'h0C);
    // AW ahead of W
    applyWriteStimulus(32'h24, 32'h0BADF00D, 4'hF, 0, 2);
    applyReadStimulus(32'h24);
    idleCycles(2);

    // Partial strobes and an all-zero strobe
    applyWriteStimulus(32'h08, 32'hFFFFFFFF, 4'hF, 0, 0);
    applyWriteStimulus(32'h0B, 32'h00000000, 4'h5, 0, 0);
    applyReadStimulus(32'h08);
    applyWriteStimulus(32'h10, 32'h12345678, 4'h0, 0, 0);
    applyReadStimulus(32'h10);

    // Top in-range register and the first out-of-range address
    applyWriteStimulus(32'h3C, 32'h7E57C0DE, 4'hF, 0, 0);
    applyReadStimulus(32'h3D);
    applyWriteStimulus(32'h40, 32'hFFFFFFFF, 4'hF, 0, 0);
    applyReadStimulus(32'h40);
    applyReadStimulus(32'h1000);
    idleCycles(2);

    // Write commit and AR capture on the same edge to the same register
    AWADDR = 32'h14; WDATA = 32'h55AA55AA; WSTRB = 4'hF; ARADDR = 32'h14;
    expB.push_back(2'b00);
    expR.push_back({2'b00, model[5]});
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("collide_readies", 64'({AWREADY, WREADY, ARREADY}), 64'd7);
    @(posedge ACLK);
    #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    modelWrite(32'h14, 32'h55AA55AA, 4'hF);
    checkOutput("collide_valids", 64'({BVALID, RVALID}), 64'd3);
    idleCycles(1);
    applyReadStimulus(32'h14);
    idleCycles(2);

    // Write response back-pressure
    BREADY = 1'b0;
    applyWriteStimulus(32'h18, 32'hCAFEF00D, 4'hF, 0, 0);
    for (int i = 0; i < 5; i++) begin
      idleCycles(1);
      checkOutput("bstall_bvalid_bresp", 64'({BVALID, BRESP}), 64'd4);
      checkOutput("bstall_readies", 64'({AWREADY, WREADY}), 64'd0);
    end
    BREADY = 1'b1;
    idleCycles(1);
    checkOutput("bstall_release", 64'({AWREADY, WREADY, BVALID}), 64'd6);

    // Read data back-pressure
    RREADY = 1'b0;
    applyReadStimulus(32'h18);
    for (int i = 0; i < 5; i++) begin
      idleCycles(1);
      checkOutput("rstall_data", 64'({RVALID, RRESP, RDATA}), {30'd0, 1'b1, 2'b00, model[6]});
      checkOutput("rstall_arready", 64'(ARREADY), 64'd0);
    end
    RREADY = 1'b1;
    idleCycles(1);
    checkOutput("rstall_release", 64'({ARREADY, RVALID}), 64'd2);
    idleCycles(2);

    // Reset while a write response is pending
    BREADY = 1'b0;
    applyWriteStimulus(32'h04, 32'hA5A5A5A5, 4'hF, 0, 0);
    ARESET = 1'b1;
    idleCycles(1);
    checkOutput("rst_mid_bvalid", 64'(BVALID), 64'd0);
    checkOutput("rst_mid_readies", 64'({AWREADY, WREADY, ARREADY}), 64'd0);
    modelReset();
    expB.delete();
    ARESET = 1'b0;
    BREADY = 1'b1;
    idleCycles(1);
    checkOutput("rst_mid_release", 64'({AWREADY, WREADY, ARREADY}), 64'd7);
    applyReadStimulus(32'h04);
    applyReadStimulus(32'h08);
    idleCycles(2);

    // A captured AW must be discarded by reset
    AWADDR = 32'h1C; AWVALID = 1'b1;
    idleCycles(1);
    AWVALID = 1'b0;
    ARESET = 1'b1;
    idleCycles(1);
    ARESET = 1'b0;
    idleCycles(1);
    applyWriteStimulus(32'h20, 32'h600DCAFE, 4'hF, 0, 0);
    applyReadStimulus(32'h1C);
    applyReadStimulus(32'h20);

    // Sweep the whole bank against the model
    for (int i = 0; i < NR; i++) applyReadStimulus(AW'(i * 4));

    for (int i = 0; i < 20 && (expB.size() > 0 || expR.size() > 0); i++) idleCycles(1);
    checkOutput("drain_b", 64'(expB.size()), 64'd0);
    checkOutput("drain_r", 64'(expR.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
